ifid_fetch_queue: RTL and testbench

//  IF/ID stage: owns the architectural fetch PC (IFID_NowPC) and registers Fetch_NextPC each cycle.

---
 rtl/ifid_fetch_queue.sv | 200 ++++++++++++++++++++
 tb/tb_ifid_fetch_queue.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifid_fetch_queue.sv
// ifid_fetch_queue
// IF/ID stage. Holds the architectural fetch PC, issues 8-byte-aligned Icache
// reads (at most one in flight), buffers the returned 64-bit blocks in a small
// circular queue and presents Decode a halfword-aligned 64-bit window that
// starts at the current PC. A branch or exception redirect flushes the queue
// and discards the response of any read that was already in flight.
module ifid_fetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] START_PC   = 32'h8000_0000,
  parameter int                    QDEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Stall,
  input  logic [ADDR_WIDTH-1:0] Fetch_NextPC,
  input  logic                  EX_BranchFlag,
  input  logic                  Ctrl_ExcpFlag,
  output logic [ADDR_WIDTH-1:0] IFID_NowPC,
  output logic [63:0]           IFID_Instr,
  output logic [3:0]            IFID_ValidBytes,
  output logic                  Icache_Req,
  output logic [ADDR_WIDTH-1:0] Icache_Addr,
  input  logic                  Icache_Ready,
  input  logic                  Icache_Valid,
  input  logic [63:0]           Icache_Data
);

  // Pointer width for the power-of-two queue, and a count width that can hold
  // the value QDEPTH itself.
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] r_now_pc;
  logic [ADDR_WIDTH-1:0] r_fetch_addr;
  logic                  r_outstanding;
  logic                  r_drop;
  logic [63:0]           r_q [QDEPTH];
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic          w_redirect;
  logic          w_cross;
  logic          w_pop;
  logic          w_push;
  logic          w_room;
  logic          w_fire;
  logic [PW-1:0] w_head_nxt;
  logic [63:0]   w_head_blk;
  logic [63:0]   w_next_blk;
  logic [1:0]    w_off;
  logic [5:0]    w_shamt;
  logic [63:0]   w_window;
  logic [3:0]    w_valid_bytes;

  // A redirect wins over Stall and over any response arriving the same cycle.
  assign w_redirect = EX_BranchFlag | Ctrl_ExcpFlag;

  // Decode advances at most 8 bytes, so crossing an 8-byte boundary retires
  // exactly the head block.
  assign w_cross = (Fetch_NextPC[ADDR_WIDTH-1:3] != r_now_pc[ADDR_WIDTH-1:3]);
  assign w_pop   = ~w_redirect & ~Stall & w_cross & (r_count != '0);

  // A response is stored unless it belongs to a read issued before a redirect
  // (Drop) or arrives in the redirect cycle itself.
  assign w_push = Icache_Valid & ~r_drop & ~w_redirect;

  // The in-flight read reserves a queue slot so its response always fits.
  assign w_room = (r_count + CW'(r_outstanding)) < CW'(QDEPTH);

  // Requests are withheld during reset so no handshake can be lost.
  assign Icache_Req  = rst_n & ~w_redirect & ~r_outstanding & w_room;
  assign Icache_Addr = r_fetch_addr;
  assign w_fire      = Icache_Req & Icache_Ready;

  // ---------------------------------------------------------------------------
  // Decode window
  // ---------------------------------------------------------------------------
  assign w_head_nxt = r_head + PW'(1);
  assign w_head_blk = r_q[r_head];
  assign w_off      = r_now_pc[2:1];
  assign w_shamt    = {w_off, 4'b0000};

  // Shift the two oldest blocks down by the halfword offset; a missing next
  // block contributes zeros so bytes past ValidBytes read as 0.
  always_comb begin
    w_next_blk    = '0;
    w_window      = '0;
    w_valid_bytes = '0;
    if (r_count >= CW'(2)) begin
      w_next_blk = r_q[w_head_nxt];
    end
    if (r_count != '0) begin
      w_window = 64'({w_next_blk, w_head_blk} >> w_shamt);
      if (r_count == CW'(1)) begin
        w_valid_bytes = 4'd8 - {1'b0, w_off, 1'b0};
      end else begin
        w_valid_bytes = 4'd8;
      end
    end
  end

  assign IFID_NowPC      = r_now_pc;
  assign IFID_Instr      = w_window;
  assign IFID_ValidBytes = w_valid_bytes;

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Architectural PC: follows Fetch_NextPC unless stalled; a redirect forces it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_now_pc <= START_PC;
    end else if (w_redirect || !Stall) begin
      r_now_pc <= Fetch_NextPC;
    end
  end

  // Fetch address, in-flight flag and stale-response drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_addr  <= {START_PC[ADDR_WIDTH-1:3], 3'b000};
      r_outstanding <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      if (w_redirect) begin
        r_fetch_addr <= {Fetch_NextPC[ADDR_WIDTH-1:3], 3'b000};
      end else if (w_fire) begin
        r_fetch_addr <= r_fetch_addr + ADDR_WIDTH'(8);
      end

      if (w_fire) begin
        r_outstanding <= 1'b1;
      end else if (Icache_Valid) begin
        r_outstanding <= 1'b0;
      end

      // A read still in flight at a redirect must have its response thrown
      // away; if the response lands in the redirect cycle it is already gone.
      if (Icache_Valid) begin
        r_drop <= 1'b0;
      end else if (w_redirect) begin
        r_drop <= r_outstanding;
      end
    end
  end

  // Queue storage: data only, validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q[r_tail] <= Icache_Data;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_redirect) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= w_head_nxt;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Interface protocol checks
  // ---------------------------------------------------------------------------

  // Every response must answer a read that is actually in flight.
  a_resp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
    Icache_Valid |-> r_outstanding);

  // Decode may only step over bytes it has been shown.
  a_decode_in_window: assert property (@(posedge clk) disable iff (!rst_n)
    (!w_redirect && !Stall) |->
      ((Fetch_NextPC - r_now_pc) <= ADDR_WIDTH'(IFID_ValidBytes)));

endmodule

// File: tb/tb_ifid_fetch_queue.sv
// Directed bench for ifid_fetch_queue. A small in-bench Icache answers each
// accepted read after a programmable latency with a block whose halfwords hold
// the low 16 bits of their own byte address, so every decode window has an
// expected value computable from the PC alone.
module tb_ifid_fetch_queue;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          Stall;
  logic [AW-1:0] Fetch_NextPC;
  logic          EX_BranchFlag;
  logic          Ctrl_ExcpFlag;
  logic [AW-1:0] IFID_NowPC;
  logic [63:0]   IFID_Instr;
  logic [3:0]    IFID_ValidBytes;
  logic          Icache_Req;
  logic [AW-1:0] Icache_Addr;
  logic          Icache_Ready;
  logic          Icache_Valid;
  logic [63:0]   Icache_Data;

  int vectors     = 0;
  int miscompares = 0;

  // Icache model state
  bit            pend      = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  int            pend_wait = 0;
  int            lat       = 1;
  bit            hs        = 1'b0;
  logic [AW-1:0] hs_addr   = '0;

  always #5 clk = ~clk;

  ifid_fetch_queue #(
    .ADDR_WIDTH (AW),
    .START_PC   (32'h8000_0000),
    .QDEPTH     (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .Stall           (Stall),
    .Fetch_NextPC    (Fetch_NextPC),
    .EX_BranchFlag   (EX_BranchFlag),
    .Ctrl_ExcpFlag   (Ctrl_ExcpFlag),
    .IFID_NowPC      (IFID_NowPC),
    .IFID_Instr      (IFID_Instr),
    .IFID_ValidBytes (IFID_ValidBytes),
    .Icache_Req      (Icache_Req),
    .Icache_Addr     (Icache_Addr),
    .Icache_Ready    (Icache_Ready),
    .Icache_Valid    (Icache_Valid),
    .Icache_Data     (Icache_Data)
  );

  // Block returned for an aligned address: halfword i holds (addr+2i)[15:0].
  function automatic logic [63:0] blk(input logic [AW-1:0] a);
    return {a[15:0] + 16'd6, a[15:0] + 16'd4, a[15:0] + 16'd2, a[15:0]};
  endfunction

  // Expected decode window at pc with vb valid bytes; invalid bytes are 0.
  function automatic logic [63:0] win(input logic [AW-1:0] pc, input int vb);
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      if (2 * i < vb) w[16*i +: 16] = pc[15:0] + 16'(2 * i);
    end
    return w;
  endfunction

  // Apply this cycle's inputs (including the Icache response) and let the
  // combinational outputs settle; remember whether a read is accepted.
  task automatic drive(input logic st, input logic [AW-1:0] npc,
                       input logic br, input logic ex, input logic rdy);
    Stall         = st;
    Fetch_NextPC  = npc;
    EX_BranchFlag = br;
    Ctrl_ExcpFlag = ex;
    Icache_Ready  = rdy;
    Icache_Valid  = pend && (pend_wait == 0);
    Icache_Data   = Icache_Valid ? blk(pend_addr) : 64'h0;
    #1;
    hs      = Icache_Req && Icache_Ready;
    hs_addr = Icache_Addr;
  endtask

  // Clock edge plus Icache model bookkeeping.
  task automatic tick();
    @(posedge clk);
    if (Icache_Valid) pend = 1'b0;
    else if (pend && pend_wait > 0) pend_wait--;
    if (hs) begin
      pend      = 1'b1;
      pend_addr = hs_addr;
      pend_wait = lat - 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (Icache_Req !== 1'b0) begin
      miscompares++; $display("FAIL reset_req: got %b expected 0", Icache_Req);
    end
    rst_n = 1'b1;
    drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (IFID_NowPC !== 32'h8000_0000) begin
      miscompares++; $display("FAIL reset_pc: got %h expected 80000000", IFID_NowPC);
    end
    vectors++;
    if (IFID_ValidBytes !== 4'd0) begin
      miscompares++; $display("FAIL reset_vb: got %0d expected 0", IFID_ValidBytes);
    end
    vectors++;
    if (IFID_Instr !== 64'h0) begin
      miscompares++; $display("FAIL reset_instr: got %h expected 0", IFID_Instr);
    end
    vectors++;
    if (Icache_Addr !== 32'h8000_0000) begin
      miscompares++; $display("FAIL reset_addr: got %h expected 80000000", Icache_Addr);
    end
  endtask

  // Decode stalled for 10 cycles: queue fills with exactly QDEPTH reads.
  task automatic test_stall_fill();
    int nreq;
    bit exp_req;
    int exp_vb;
    nreq = 0;
    lat  = 1;
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
      exp_req = (c % 2 == 0) && (c <= 6);
      exp_vb  = (c < 2) ? 0 : 8;
      vectors++;
      if (Icache_Req !== exp_req) begin
        miscompares++; $display("FAIL stall_req c%0d: got %b expected %b", c, Icache_Req, exp_req);
      end
      if (exp_req) begin
        vectors++;
        if (Icache_Addr !== 32'h8000_0000 + 32'(4 * c)) begin
          miscompares++; $display("FAIL stall_addr c%0d: got %h expected %h", c, Icache_Addr, 32'h8000_0000 + 32'(4 * c));
        end
      end
      vectors++;
      if (IFID_NowPC !== 32'h8000_0000) begin
        miscompares++; $display("FAIL stall_pc c%0d: got %h expected 80000000", c, IFID_NowPC);
      end
      vectors++;
      if (IFID_ValidBytes !== 4'(exp_vb)) begin
        miscompares++; $display("FAIL stall_vb c%0d: got %0d expected %0d", c, IFID_ValidBytes, exp_vb);
      end
      vectors++;
      if (IFID_Instr !== win(32'h8000_0000, exp_vb)) begin
        miscompares++; $display("FAIL stall_instr c%0d: got %h expected %h", c, IFID_Instr, win(32'h8000_0000, exp_vb));
      end
      if (hs) nreq++;
      tick();
    end
    vectors++;
    if (nreq !== 4) begin
      miscompares++; $display("FAIL stall_nreq: got %0d expected 4", nreq);
    end
  endtask

  // Decode consumes 4 bytes per cycle from the full queue; requests resume
  // the cycle after the first pop and the window stays 8 bytes wide.
  task automatic test_stream();
    logic [AW-1:0] pc;
    bit exp_req;
    for (int i = 0; i < 8; i++) begin
      pc = 32'h8000_0000 + 32'(4 * i);
      drive(1'b0, pc + 32'd4, 1'b0, 1'b0, 1'b1);
      exp_req = (i >= 2) && (i % 2 == 0);
      vectors++;
      if (IFID_NowPC !== pc) begin
        miscompares++; $display("FAIL stream_pc i%0d: got %h expected %h", i, IFID_NowPC, pc);
      end
      vectors++;
      if (IFID_ValidBytes !== 4'd8) begin
        miscompares++; $display("FAIL stream_vb i%0d: got %0d expected 8", i, IFID_ValidBytes);
      end
      vectors++;
      if (IFID_Instr !== win(pc, 8)) begin
        miscompares++; $display("FAIL stream_instr i%0d: got %h expected %h", i, IFID_Instr, win(pc, 8));
      end
      vectors++;
      if (Icache_Req !== exp_req) begin
        miscompares++; $display("FAIL stream_req i%0d: got %b expected %b", i, Icache_Req, exp_req);
      end
      if (exp_req) begin
        vectors++;
        if (Icache_Addr !== 32'h8000_0020 + 32'(4 * (i - 2))) begin
          miscompares++; $display("FAIL stream_addr i%0d: got %h expected %h", i, Icache_Addr, 32'h8000_0020 + 32'(4 * (i - 2)));
        end
      end
      tick();
    end
  endtask

  // Branch while a read is in flight: its late response must be dropped.
  task automatic test_redirect_drop();
    lat = 3;
    drive(1'b1, 32'h8000_0020, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (Icache_Req !== 1'b1 || Icache_Addr !== 32'h8000_0038) begin
      miscompares++; $display("FAIL drop_preq: got %b/%h expected 1/80000038", Icache_Req, Icache_Addr);
    end
    tick();
    drive(1'b0, 32'h8000_1002, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (Icache_Req !== 1'b0) begin
      miscompares++; $display("FAIL drop_redir_req: got %b expected 0", Icache_Req);
    end
    tick();
    lat = 1;
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 32'h8000_1002, 1'b0, 1'b0, 1'b1);
      vectors++;
      if (IFID_NowPC !== 32'h8000_1002) begin
        miscompares++; $display("FAIL drop_pc c%0d: got %h expected 80001002", c, IFID_NowPC);
      end
      vectors++;
      if (IFID_ValidBytes !== 4'd0 || Icache_Req !== 1'b0) begin
        miscompares++; $display("FAIL drop_wait c%0d: got vb=%0d req=%b expected vb=0 req=0", c, IFID_ValidBytes, Icache_Req);
      end
      tick();
    end
    drive(1'b0, 32'h8000_1002, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (Icache_Req !== 1'b1 || Icache_Addr !== 32'h8000_1000) begin
      miscompares++; $display("FAIL drop_newreq: got %b/%h expected 1/80001000", Icache_Req, Icache_Addr);
    end
    tick();
    drive(1'b0, 32'h8000_1002, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (IFID_ValidBytes !== 4'd0) begin
      miscompares++; $display("FAIL drop_vb_pre: got %0d expected 0", IFID_ValidBytes);
    end
    tick();
    drive(1'b1, 32'h8000_1002, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (IFID_ValidBytes !== 4'd6) begin
      miscompares++; $display("FAIL drop_vb_first: got %0d expected 6", IFID_ValidBytes);
    end
    vectors++;
    if (IFID_Instr !== win(32'h8000_1002, 6)) begin
      miscompares++; $display("FAIL drop_instr: got %h expected %h", IFID_Instr, win(32'h8000_1002, 6));
    end
    vectors++;
    if (Icache_Req !== 1'b1 || Icache_Addr !== 32'h8000_1008) begin
      miscompares++; $display("FAIL drop_seq_req: got %b/%h expected 1/80001008", Icache_Req, Icache_Addr);
    end
    tick();
    drive(1'b1, 32'h8000_1002, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  // Exception redirect in the same cycle a response returns.
  task automatic test_redirect_valid();
    drive(1'b1, 32'h8000_1002, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (IFID_ValidBytes !== 4'd8 || IFID_Instr !== win(32'h8000_1002, 8)) begin
      miscompares++; $display("FAIL rv_window: got %0d/%h expected 8/%h", IFID_ValidBytes, IFID_Instr, win(32'h8000_1002, 8));
    end
    vectors++;
    if (Icache_Req !== 1'b1 || Icache_Addr !== 32'h8000_1010) begin
      miscompares++; $display("FAIL rv_preq: got %b/%h expected 1/80001010", Icache_Req, Icache_Addr);
    end
    tick();
    drive(1'b0, 32'h8000_2000, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (Icache_Req !== 1'b0) begin
      miscompares++; $display("FAIL rv_redir_req: got %b expected 0", Icache_Req);
    end
    tick();
    drive(1'b0, 32'h8000_2000, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (IFID_NowPC !== 32'h8000_2000 || IFID_ValidBytes !== 4'd0) begin
      miscompares++; $display("FAIL rv_after: got pc=%h vb=%0d expected pc=80002000 vb=0", IFID_NowPC, IFID_ValidBytes);
    end
    vectors++;
    if (Icache_Req !== 1'b1 || Icache_Addr !== 32'h8000_2000) begin
      miscompares++; $display("FAIL rv_newreq: got %b/%h expected 1/80002000", Icache_Req, Icache_Addr);
    end
    tick();
    drive(1'b0, 32'h8000_2000, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h8000_3006, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (IFID_ValidBytes !== 4'd8 || IFID_Instr !== win(32'h8000_2000, 8)) begin
      miscompares++; $display("FAIL rv_pushed: got %0d/%h expected 8/%h", IFID_ValidBytes, IFID_Instr, win(32'h8000_2000, 8));
    end
    vectors++;
    if (Icache_Req !== 1'b0) begin
      miscompares++; $display("FAIL rv_idle_redir_req: got %b expected 0", Icache_Req);
    end
    tick();
  endtask

  // PC at the last halfword of a block with only that block present.
  task automatic test_window_split();
    drive(1'b1, 32'h8000_3006, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (IFID_NowPC !== 32'h8000_3006 || IFID_ValidBytes !== 4'd0) begin
      miscompares++; $display("FAIL win_start: got pc=%h vb=%0d expected pc=80003006 vb=0", IFID_NowPC, IFID_ValidBytes);
    end
    vectors++;
    if (Icache_Req !== 1'b1 || Icache_Addr !== 32'h8000_3000) begin
      miscompares++; $display("FAIL win_req0: got %b/%h expected 1/80003000", Icache_Req, Icache_Addr);
    end
    tick();
    drive(1'b1, 32'h8000_3006, 1'b0, 1'b0, 1'b1);
    tick();
    lat = 3;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 32'h8000_3006, 1'b0, 1'b0, 1'b1);
      vectors++;
      if (IFID_ValidBytes !== 4'd2) begin
        miscompares++; $display("FAIL win_vb2 c%0d: got %0d expected 2", c, IFID_ValidBytes);
      end
      vectors++;
      if (IFID_Instr !== win(32'h8000_3006, 2)) begin
        miscompares++; $display("FAIL win_instr2 c%0d: got %h expected %h", c, IFID_Instr, win(32'h8000_3006, 2));
      end
      if (c == 0) begin
        vectors++;
        if (Icache_Req !== 1'b1 || Icache_Addr !== 32'h8000_3008) begin
          miscompares++; $display("FAIL win_req1: got %b/%h expected 1/80003008", Icache_Req, Icache_Addr);
        end
      end
      tick();
    end
    drive(1'b1, 32'h8000_3006, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (IFID_ValidBytes !== 4'd8 || IFID_Instr !== win(32'h8000_3006, 8)) begin
      miscompares++; $display("FAIL win_join: got %0d/%h expected 8/%h", IFID_ValidBytes, IFID_Instr, win(32'h8000_3006, 8));
    end
    vectors++;
    if (Icache_Req !== 1'b1 || Icache_Addr !== 32'h8000_3010) begin
      miscompares++; $display("FAIL win_req2: got %b/%h expected 1/80003010", Icache_Req, Icache_Addr);
    end
    tick();
  endtask

  // Reset while a read is in flight; the Icache stays silent afterwards.
  task automatic test_reset_mid();
    pend  = 1'b0;
    rst_n = 1'b0;
    drive(1'b1, 32'h8000_3006, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (Icache_Req !== 1'b0) begin
      miscompares++; $display("FAIL rmid_req_in_reset: got %b expected 0", Icache_Req);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (IFID_NowPC !== 32'h8000_0000 || IFID_ValidBytes !== 4'd0 || IFID_Instr !== 64'h0) begin
        miscompares++; $display("FAIL rmid_state c%0d: got pc=%h vb=%0d instr=%h expected 80000000/0/0", c, IFID_NowPC, IFID_ValidBytes, IFID_Instr);
      end
      vectors++;
      if (Icache_Req !== 1'b1 || Icache_Addr !== 32'h8000_0000) begin
        miscompares++; $display("FAIL rmid_req c%0d: got %b/%h expected 1/80000000", c, Icache_Req, Icache_Addr);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stall_fill();
    test_stream();
    test_redirect_drop();
    test_redirect_valid();
    test_window_split();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
